// File: rtl/pin_verifier.sv
// PIN entry and verification controller for a card terminal.
// Collects four BCD keypad digits and compares them with PIN_REF on
// confirm. A correct PIN pulses PIN. A wrong PIN pulses ERR and uses
// up one attempt. Running out of attempts blocks the card until reset.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   EN                  card present / session enable
//   KEY_VALID/KEY_DIGIT digit strobe and BCD digit
//   KEY_CLR, KEY_OK     clear entry, confirm entry
//   PIN_REF             stored PIN, first digit in [15:12]
//   PIN, ERR            one-cycle result pulses
//   BLOQ                sticky card-blocked flag
//   TENT                attempts remaining
//   DIG_CNT             digits currently entered (0..4)
module pin_verifier #(
   parameter int MAX_TENT    = 3,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic        KEY_VALID,
   input  logic [3:0]  KEY_DIGIT,
   input  logic        KEY_CLR,
   input  logic        KEY_OK,
   input  logic [15:0] PIN_REF,
   output logic        PIN,
   output logic        ERR,
   output logic        BLOQ,
   output logic [1:0]  TENT,
   output logic [2:0]  DIG_CNT
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTRY   = 3'd1;
   localparam logic [2:0] S_CHECK   = 3'd2;
   localparam logic [2:0] S_OK      = 3'd3;
   localparam logic [2:0] S_BLOCKED = 3'd4;

   localparam logic [1:0] TENT_INIT = 2'(MAX_TENT);
   localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
   // Timer holds the number of idle cycles already seen; the
   // TIMEOUT_CYC-th idle cycle is the one that discards the entry.
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   logic [2:0]    state;
   logic [15:0]   entry;
   logic [TW-1:0] timer;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         entry   <= '0;
         DIG_CNT <= '0;
         TENT    <= TENT_INIT;
         PIN     <= 1'b0;
         ERR     <= 1'b0;
         BLOQ    <= 1'b0;
         timer   <= '0;
      end else begin
         PIN <= 1'b0;
         ERR <= 1'b0;
         unique case (state)
            S_IDLE: begin
               timer <= '0;
               if (EN) begin
                  state   <= S_ENTRY;
                  TENT    <= TENT_INIT;
                  entry   <= '0;
                  DIG_CNT <= '0;
               end
            end
            S_ENTRY: begin
               if (!EN) begin
                  state   <= S_IDLE;
                  entry   <= '0;
                  DIG_CNT <= '0;
                  timer   <= '0;
               end else if (KEY_CLR) begin
                  entry   <= '0;
                  DIG_CNT <= '0;
                  timer   <= '0;
               end else if (KEY_OK) begin
                  timer <= '0;
                  if (DIG_CNT == 3'd4) state <= S_CHECK;
               end else if (KEY_VALID) begin
                  timer <= '0;
                  if (KEY_DIGIT <= 4'd9 && DIG_CNT < 3'd4) begin
                     entry   <= {entry[11:0], KEY_DIGIT};
                     DIG_CNT <= DIG_CNT + 3'd1;
                  end
               end else if (timer == T_LAST) begin
                  entry   <= '0;
                  DIG_CNT <= '0;
                  timer   <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_CHECK: begin
               timer <= '0;
               if (!EN) begin
                  // Card pulled during the compare: no verdict at all.
                  state   <= S_IDLE;
                  entry   <= '0;
                  DIG_CNT <= '0;
               end else if (entry == PIN_REF) begin
                  PIN   <= 1'b1;
                  state <= S_OK;
               end else begin
                  ERR     <= 1'b1;
                  TENT    <= TENT - 2'd1;
                  entry   <= '0;
                  DIG_CNT <= '0;
                  if (TENT == 2'd1) begin
                     state <= S_BLOCKED;
                     BLOQ  <= 1'b1;
                  end else begin
                     state <= S_ENTRY;
                  end
               end
            end
            S_OK: begin
               timer <= '0;
               if (!EN) begin
                  state   <= S_IDLE;
                  entry   <= '0;
                  DIG_CNT <= '0;
               end
            end
            S_BLOCKED: begin
               timer <= '0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pin_verifier.sv
// Self-checking bench for pin_verifier.
// Expected verdicts go to a queue on confirm and are popped at the pulse.
module tb_pin_verifier;

   localparam int TO = 20;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        EN = 1'b0;
   logic        KEY_VALID = 1'b0;
   logic [3:0]  KEY_DIGIT = 4'd0;
   logic        KEY_CLR = 1'b0;
   logic        KEY_OK = 1'b0;
   logic [15:0] PIN_REF = 16'h1234;
   logic        PIN;
   logic        ERR;
   logic        BLOQ;
   logic [1:0]  TENT;
   logic [2:0]  DIG_CNT;

   int checks = 0;
   int failures = 0;
   int pin_seen = 0;
   int err_seen = 0;
   logic [15:0] mdl_buf = '0;
   int          mdl_cnt = 0;
   logic [1:0]  exp_q[$];
   logic [1:0]  expv;

   always #5 CLK = ~CLK;

   pin_verifier #(.MAX_TENT(3), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .KEY_VALID(KEY_VALID), .KEY_DIGIT(KEY_DIGIT),
      .KEY_CLR(KEY_CLR), .KEY_OK(KEY_OK), .PIN_REF(PIN_REF),
      .PIN(PIN), .ERR(ERR), .BLOQ(BLOQ), .TENT(TENT), .DIG_CNT(DIG_CNT)
   );

   always @(negedge CLK) begin
      if (PIN) pin_seen++;
      if (ERR) err_seen++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic mdl_clear();
      mdl_buf = '0;
      mdl_cnt = 0;
   endtask

   task automatic press(input logic [3:0] d);
      KEY_VALID = 1'b1;
      KEY_DIGIT = d;
      tick();
      KEY_VALID = 1'b0;
      if (d <= 4'd9 && mdl_cnt < 4) begin
         mdl_buf = {mdl_buf[11:0], d};
         mdl_cnt++;
      end
   endtask

   task automatic enter4(input logic [15:0] v);
      for (int i = 0; i < 4; i++) press(v[15-4*i -: 4]);
   endtask

   // Confirm; ref_at_check is the PIN_REF the bench will hold in CHECK.
   task automatic ok_push(input logic [15:0] ref_at_check);
      if (mdl_cnt == 4)
         exp_q.push_back((mdl_buf == ref_at_check) ? 2'b10 : 2'b01);
      KEY_OK = 1'b1;
      tick();
      KEY_OK = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      EN = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      mdl_clear();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({PIN, ERR, BLOQ} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000", {PIN, ERR, BLOQ});
      end
      checks++;
      if (TENT !== 2'd3 || DIG_CNT !== 3'd0) begin
         failures++;
         $display("FAIL reset_cnt got tent=%0d cnt=%0d exp 3 0", TENT, DIG_CNT);
      end
   endtask

   task automatic test_correct();
      int p0;
      EN = 1'b1;
      tick();
      enter4(16'h1234);
      checks++;
      if (DIG_CNT !== 3'(mdl_cnt)) begin
         failures++;
         $display("FAIL cnt4 got=%0d exp=%0d", DIG_CNT, mdl_cnt);
      end
      ok_push(PIN_REF);
      checks++;
      if ({PIN, ERR} !== 2'b00) begin
         failures++;
         $display("FAIL early_pulse got=%b exp=00", {PIN, ERR});
      end
      tick();
      expv = exp_q.pop_front();
      checks++;
      if ({PIN, ERR} !== expv) begin
         failures++;
         $display("FAIL pin_pulse got=%b exp=%b", {PIN, ERR}, expv);
      end
      tick();
      checks++;
      if ({PIN, ERR} !== 2'b00 || TENT !== 2'd3) begin
         failures++;
         $display("FAIL pin_one_cycle got=%b tent=%0d exp=00 3", {PIN, ERR}, TENT);
      end
      p0 = pin_seen + err_seen;
      KEY_OK = 1'b1;
      tick();
      KEY_OK = 1'b0;
      tick();
      tick();
      checks++;
      if (pin_seen + err_seen !== p0) begin
         failures++;
         $display("FAIL ok_ignores got=%0d exp=%0d", pin_seen + err_seen, p0);
      end
      EN = 1'b0;
      tick();
      mdl_clear();
      checks++;
      if (DIG_CNT !== 3'd0) begin
         failures++;
         $display("FAIL ok_to_idle got=%0d exp=0", DIG_CNT);
      end
   endtask

   task automatic test_wrong();
      int p0;
      EN = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         enter4(16'h1235);
         ok_push(PIN_REF);
         tick();
         expv = exp_q.pop_front();
         checks++;
         if ({PIN, ERR} !== expv || TENT !== 2'(2 - i)) begin
            failures++;
            $display("FAIL err_%0d got=%b tent=%0d exp=%b %0d",
                     i, {PIN, ERR}, TENT, expv, 2 - i);
         end
         mdl_clear();
         checks++;
         if (DIG_CNT !== 3'd0 || BLOQ !== (i == 2)) begin
            failures++;
            $display("FAIL after_err_%0d got cnt=%0d bloq=%b", i, DIG_CNT, BLOQ);
         end
      end
      p0 = pin_seen;
      enter4(16'h1234);
      KEY_OK = 1'b1;
      tick();
      KEY_OK = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (pin_seen !== p0 || BLOQ !== 1'b1) begin
         failures++;
         $display("FAIL blocked_pin got=%0d bloq=%b exp=%0d 1", pin_seen, BLOQ, p0);
      end
      EN = 1'b0;
      tick();
      tick();
      checks++;
      if (BLOQ !== 1'b1) begin
         failures++;
         $display("FAIL bloq_sticky got=%b exp=1", BLOQ);
      end
   endtask

   task automatic test_blocked_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      mdl_clear();
      checks++;
      if (BLOQ !== 1'b0 || TENT !== 2'd3 || DIG_CNT !== 3'd0) begin
         failures++;
         $display("FAIL unblock got bloq=%b tent=%0d cnt=%0d", BLOQ, TENT, DIG_CNT);
      end
   endtask

   task automatic test_ignore();
      int p0;
      EN = 1'b1;
      tick();
      press(4'd1);
      press(4'd2);
      p0 = pin_seen + err_seen;
      ok_push(PIN_REF);
      tick();
      tick();
      checks++;
      if (pin_seen + err_seen !== p0 || DIG_CNT !== 3'd2) begin
         failures++;
         $display("FAIL short_ok got cnt=%0d pulses=%0d exp 2 %0d",
                  DIG_CNT, pin_seen + err_seen, p0);
      end
      press(4'd12);
      checks++;
      if (DIG_CNT !== 3'(mdl_cnt)) begin
         failures++;
         $display("FAIL bad_digit got=%0d exp=%0d", DIG_CNT, mdl_cnt);
      end
      press(4'd3);
      press(4'd4);
      press(4'd9);
      checks++;
      if (DIG_CNT !== 3'd4) begin
         failures++;
         $display("FAIL fifth_digit got=%0d exp=4", DIG_CNT);
      end
      ok_push(PIN_REF);
      tick();
      expv = exp_q.pop_front();
      checks++;
      if ({PIN, ERR} !== expv) begin
         failures++;
         $display("FAIL ignore_pin got=%b exp=%b", {PIN, ERR}, expv);
      end
      EN = 1'b0;
      tick();
      mdl_clear();
   endtask

   task automatic test_ref_sample();
      EN = 1'b1;
      tick();
      enter4(16'h5678);
      ok_push(16'h5678);
      PIN_REF = 16'h5678;
      tick();
      PIN_REF = 16'h1234;
      expv = exp_q.pop_front();
      checks++;
      if ({PIN, ERR} !== expv) begin
         failures++;
         $display("FAIL ref_in_check got=%b exp=%b", {PIN, ERR}, expv);
      end
      EN = 1'b0;
      tick();
      mdl_clear();
   endtask

   task automatic test_clr_ok();
      int p0;
      EN = 1'b1;
      tick();
      enter4(16'h1234);
      p0 = pin_seen + err_seen;
      KEY_CLR = 1'b1;
      KEY_OK = 1'b1;
      tick();
      KEY_CLR = 1'b0;
      KEY_OK = 1'b0;
      mdl_clear();
      tick();
      tick();
      checks++;
      if (DIG_CNT !== 3'd0 || TENT !== 2'd3 || pin_seen + err_seen !== p0) begin
         failures++;
         $display("FAIL clr_over_ok got cnt=%0d tent=%0d pulses=%0d",
                  DIG_CNT, TENT, pin_seen + err_seen - p0);
      end
   endtask

   task automatic test_timeout();
      press(4'd1);
      press(4'd2);
      for (int i = 0; i < TO - 1; i++) tick();
      checks++;
      if (DIG_CNT !== 3'd2) begin
         failures++;
         $display("FAIL pre_timeout got=%0d exp=2", DIG_CNT);
      end
      tick();
      mdl_clear();
      checks++;
      if (DIG_CNT !== 3'd0 || TENT !== 2'd3) begin
         failures++;
         $display("FAIL timeout got cnt=%0d tent=%0d exp 0 3", DIG_CNT, TENT);
      end
   endtask

   task automatic test_en_drop_check();
      int p0;
      enter4(16'h1235);
      p0 = pin_seen + err_seen;
      KEY_OK = 1'b1;
      tick();
      KEY_OK = 1'b0;
      EN = 1'b0;
      tick();
      tick();
      mdl_clear();
      checks++;
      if (pin_seen + err_seen !== p0 || DIG_CNT !== 3'd0 || TENT !== 2'd3) begin
         failures++;
         $display("FAIL en_drop got pulses=%0d cnt=%0d tent=%0d",
                  pin_seen + err_seen - p0, DIG_CNT, TENT);
      end
   endtask

   task automatic test_rst_check();
      int p0;
      EN = 1'b1;
      tick();
      enter4(16'h1235);
      p0 = pin_seen + err_seen;
      KEY_OK = 1'b1;
      tick();
      KEY_OK = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
      mdl_clear();
      checks++;
      if (pin_seen + err_seen !== p0 || TENT !== 2'd3) begin
         failures++;
         $display("FAIL rst_in_check got pulses=%0d tent=%0d",
                  pin_seen + err_seen - p0, TENT);
      end
   endtask

   initial begin
      test_reset();
      test_correct();
      test_wrong();
      test_blocked_reset();
      test_ignore();
      test_ref_sample();
      test_clr_ok();
      test_timeout();
      test_en_drop_check();
      test_rst_check();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pin_verifier.md
PIN_VERIFIER -- requirements
Module: pin_verifier

Interface
REQ-001 SHALL have parameter MAX_TENT, default 3, number of wrong-PIN attempts before the card is blocked (1..3).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000, idle cycles in ENTRY before the partial entry is discarded.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port EN  input  1  card-present / session enable.
REQ-006 SHALL have port KEY_VALID  input  1  one-cycle strobe qualifying KEY_DIGIT.
REQ-007 SHALL have port KEY_DIGIT  input  4  keypad digit, BCD 0..9.
REQ-008 SHALL have port KEY_CLR  input  1  clear the current entry.
REQ-009 SHALL have port KEY_OK  input  1  confirm the entry.
REQ-010 SHALL have port PIN_REF  input  16  stored PIN, 4 BCD digits; first digit in [15:12].
REQ-011 SHALL have port PIN  output  1  one-cycle pulse on a correct PIN; drives the downstream MB PIN input.
REQ-012 SHALL have port ERR  output  1  one-cycle pulse on a wrong PIN.
REQ-013 SHALL have port BLOQ  output  1  card blocked, sticky.
REQ-014 SHALL have port TENT  output  2  attempts remaining.
REQ-015 SHALL have port DIG_CNT  output  3  digits currently entered, 0..4.

Function
REQ-016 SHALL implement the states IDLE, ENTRY, CHECK, OK and BLOCKED; all outputs SHALL be registered.
REQ-017 In IDLE, EN=1 SHALL move the block to ENTRY on the next edge, reload TENT=MAX_TENT, and clear the buffer and DIG_CNT.
REQ-018 ENTRY priority SHALL be: KEY_CLR over KEY_OK over KEY_VALID; only the highest-priority key in a cycle takes effect.
REQ-019 In ENTRY, KEY_CLR SHALL clear the buffer and set DIG_CNT=0; TENT SHALL be unchanged.
REQ-020 In ENTRY, KEY_VALID with KEY_DIGIT<=9 and DIG_CNT<4 SHALL shift the digit into the buffer (left shift, new digit at [3:0]) and increment DIG_CNT.
REQ-021 KEY_VALID with KEY_DIGIT 10..15, or with DIG_CNT=4, SHALL be ignored.
REQ-022 In ENTRY, KEY_OK with DIG_CNT=4 SHALL move the block to CHECK; KEY_OK with DIG_CNT<4 SHALL be ignored.
REQ-023 CHECK SHALL last exactly one cycle and compare the buffer with PIN_REF.
REQ-024 For KEY_OK sampled at edge k, PIN or ERR SHALL be high for exactly the one cycle following edge k+1.
REQ-025 On a match, the block SHALL pulse PIN, go to OK and leave TENT unchanged.
REQ-026 On a mismatch, the block SHALL pulse ERR and decrement TENT.
REQ-027 After a mismatch, if the new TENT=0 the block SHALL go to BLOCKED with BLOQ=1; otherwise it SHALL return to ENTRY with the buffer cleared and DIG_CNT=0.
REQ-028 OK SHALL ignore all keys and return to IDLE when EN=0.
REQ-029 BLOCKED SHALL ignore keys and EN; it SHALL be left only by RST. PIN SHALL never pulse while BLOQ=1.
REQ-030 EN=0 in ENTRY or CHECK SHALL return the block to IDLE on the next edge, clear the buffer and DIG_CNT, and produce no PIN or ERR pulse, including when EN drops in the CHECK cycle.
REQ-031 Inactivity timer, ENTRY only: any KEY_VALID, KEY_CLR or KEY_OK SHALL reset it to 0.
REQ-032 When the inactivity timer reaches TIMEOUT_CYC, the buffer and DIG_CNT SHALL clear and the timer SHALL restart; TENT SHALL be unchanged and the state SHALL stay ENTRY.
REQ-033 PIN_REF SHALL be sampled only in the CHECK cycle.

Reset
REQ-034 RST=1 SHALL dominate every input and state.
REQ-035 On RST the block SHALL set state=IDLE, buffer=0, DIG_CNT=0, TENT=MAX_TENT, PIN=0, ERR=0, BLOQ=0 and timer=0.
REQ-036 RST asserted mid-entry or during CHECK SHALL suppress any pending PIN or ERR pulse.

Verification
REQ-037 PIN_REF=16'h1234, EN=1, then keys 1,2,3,4, then OK -> PIN=1 for exactly one cycle two edges after OK, state OK, TENT=3.
REQ-038 Keys 1,2,3,5 then OK, three times -> ERR pulses with TENT 2, 1, 0; after the third, BLOQ=1; a following correct 1,2,3,4 entry SHALL produce no PIN pulse.
REQ-039 Keys 1,2 then OK -> ignored, DIG_CNT=2; key 12 -> ignored; keys 3,4,9 -> DIG_CNT=4 with the buffer holding 1234; OK -> PIN pulse.
REQ-040 KEY_CLR and KEY_OK in the same cycle with DIG_CNT=4 -> DIG_CNT=0, no CHECK, no pulse.
REQ-041 Keys 1,2 followed by TIMEOUT_CYC idle cycles -> DIG_CNT=0 and TENT unchanged; EN dropped in the CHECK cycle -> IDLE with no PIN or ERR pulse.
REQ-042 RST pulse while BLOQ=1 -> BLOQ=0, TENT=3, state IDLE.
